inference_seq_ctrl: RTL and testbench
=====================================

# inference_seq_ctrl

Top-level sequencer for the digit-recognition inference engine. It owns the single streaming load port and steers each accepted word into the w12, b12, w23, b23 and image memories with the correct write enable and address. It then sequences stage1 and stage2 with start pulses, waits on their done flags under a watchdog, and reports completion or error to the host/testbench.

## Interface
Parameters:
- N_IN, 256, image pixels and image-memory depth
- N_HID, 20, hidden nodes; w12 depth = N_HID*N_IN = 5120
- N_OUT, 10, output nodes; w23 depth = N_OUT*N_HID = 200
- TIMEOUT, 16384, maximum cycles allowed in any stage wait state

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_load_all  in  1  pulse: load all weights, biases and image
- cmd_load_img  in  1  pulse: reload the image only
- cmd_run  in  1  pulse: run one inference
- ld_valid  in  1  load word valid
- ld_data  in  16  load word (Q6.10; image uses bits [1:0])
- ld_ready  out  1  load word accepted when ld_valid&ld_ready
- wr_data  out  16  registered write data to all memories
- w12_we / w12_addr  out  1 / 13  w12 memory write
- b12_we / b12_addr  out  1 / 5  b12 memory write
- w23_we / w23_addr  out  1 / 8  w23 memory write
- b23_we / b23_addr  out  1 / 4  b23 memory write
- img_we / img_addr  out  1 / 9  image memory write
- stage1_start / stage2_start  out  1  single-cycle start pulses
- stage1_done / stage2_done  in  1  level done flags; only rising edges are used
- busy  out  1  state is not IDLE, READY or ERROR
- weights_valid  out  1  full parameter set has been loaded
- infer_done  out  1  single-cycle pulse when an inference completes
- err  out  1  sticky watchdog error

## Operation
- States: IDLE, LD_W12, LD_B12, LD_W23, LD_B23, LD_IMG, READY, S1_START, S1_WAIT, S2_START, S2_WAIT, DONE, ERROR.
- Command acceptance:
  - Commands are sampled only in IDLE or READY. They are ignored in every other state.
  - Priority when pulses coincide: load_all > load_img > run.
- cmd_load_all goes to LD_W12 and clears weights_valid.
- cmd_load_img is accepted only when weights_valid=1 and goes to LD_IMG.
- cmd_run is accepted only in READY and goes to S1_START.
- Load states:
  - ld_ready=1 in LD_* states only.
  - Each accepted beat writes one word at a per-memory address counter. The counter starts at 0 on state entry and increments by 1 per beat.
  - The state advances in the same cycle the last beat is accepted: W12 (5120 beats) → B12 (20) → W23 (200) → B23 (10) → IMG (256) → READY.
  - weights_valid is set on leaving LD_B23.
  - Idle cycles between beats (ld_valid=0) are allowed; counters hold.
- Run states:
  - S1_START asserts stage1_start for one cycle, then goes to S1_WAIT.
  - S1_WAIT leaves on a rising edge of stage1_done (registered edge detect). The same pattern applies to stage2.
  - S2_WAIT goes to DONE. DONE pulses infer_done, then returns to READY. A rerun uses the same image.
- Watchdog:
  - A 15-bit counter clears on entry to each WAIT state and increments every cycle in it.
  - If it reaches TIMEOUT-1 without a done edge, the state goes to ERROR and err=1.
  - ERROR is exited only by reset.
- A done edge arriving outside its WAIT state is ignored and does not carry over.

## Timing
- Reset values:
  - All outputs 0, including weights_valid, err and ld_ready.
  - State IDLE, all counters 0, edge-detect registers 0.
- Write latency: a beat accepted at cycle N produces we=1 with its addr and wr_data at cycle N+1. Exactly one we is high per cycle.
- Command-to-load latency: a command at cycle N gives ld_ready=1 at cycle N+1.
- Run latency: cmd_run at cycle N gives stage1_start=1 at N+1.
- A stage1_done rise sampled at M gives stage2_start=1 at M+2.
- A stage2_done rise sampled at M gives infer_done=1 at M+2 and READY at M+3.
- A full load is exactly 5606 accepted beats.
- Reset mid-load or mid-run returns to IDLE next cycle with weights_valid=0. Memory contents are not scrubbed.

## Test plan
- Reset, then cmd_load_all with 5606 back-to-back beats. Check:
  - w12_we on cycles 1–5120 with addresses 0..5119.
  - b12 addresses 0..19, w23 0..199, b23 0..9, img 0..255.
  - READY reached and weights_valid=1.
- Load with ld_valid toggling every other cycle. Check no address skips or repeats and no we while ld_valid=0.
- cmd_run in READY; stage1_done rises 5140 cycles later, stage2_done 300 cycles after stage2_start. Check:
  - Single-cycle start pulses.
  - One infer_done pulse.
  - Return to READY and busy=0.
- cmd_run in IDLE, or cmd_load_img before weights_valid: check both are ignored and the state stays IDLE.
- Coincident cmd_load_img and cmd_run in READY: check LD_IMG is entered and exactly 256 image writes occur.
- Hold stage1_done low for TIMEOUT cycles: check err=1 sticky, commands ignored, and reset clears it.

Source files
------------

// File: rtl/inference_seq_ctrl.sv
// ---------------------------------------------------------------------------
// inference_seq_ctrl
//
// Top-level sequencer of the digit-recognition inference engine.
//   * Owns the streaming load port (ld_valid/ld_ready/ld_data) and steers every
//     accepted word into the w12, b12, w23, b23 and image memories, one write
//     enable per cycle, with a registered address and registered write data.
//   * Sequences stage1 and stage2 with single-cycle start pulses, waits for the
//     rising edge of each level done flag under a watchdog, and reports
//     completion (infer_done) or a sticky error (err).
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   cmd_load_all/img/run         command pulses (sampled in IDLE/READY only)
//   ld_valid, ld_data, ld_ready  load stream handshake
//   wr_data, *_we, *_addr        memory write bus (registered)
//   stage*_start / stage*_done   stage handshake
//   busy, weights_valid,
//   infer_done, err              status
// ---------------------------------------------------------------------------
module inference_seq_ctrl #(
    parameter int N_IN    = 256,
    parameter int N_HID   = 20,
    parameter int N_OUT   = 10,
    parameter int TIMEOUT = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_load_all,
    input  logic        cmd_load_img,
    input  logic        cmd_run,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    output logic [15:0] wr_data,
    output logic        w12_we,
    output logic [12:0] w12_addr,
    output logic        b12_we,
    output logic [4:0]  b12_addr,
    output logic        w23_we,
    output logic [7:0]  w23_addr,
    output logic        b23_we,
    output logic [3:0]  b23_addr,
    output logic        img_we,
    output logic [8:0]  img_addr,
    output logic        stage1_start,
    output logic        stage2_start,
    input  logic        stage1_done,
    input  logic        stage2_done,
    output logic        busy,
    output logic        weights_valid,
    output logic        infer_done,
    output logic        err
);

    localparam int W12_LAST = N_HID * N_IN - 1;
    localparam int B12_LAST = N_HID - 1;
    localparam int W23_LAST = N_OUT * N_HID - 1;
    localparam int B23_LAST = N_OUT - 1;
    localparam int IMG_LAST = N_IN - 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LD_W12   = 4'd1,
        LD_B12   = 4'd2,
        LD_W23   = 4'd3,
        LD_B23   = 4'd4,
        LD_IMG   = 4'd5,
        READY    = 4'd6,
        S1_START = 4'd7,
        S1_WAIT  = 4'd8,
        S2_START = 4'd9,
        S2_WAIT  = 4'd10,
        DONE     = 4'd11,
        ERROR    = 4'd12
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] cnt_q;          // shared beat counter, cleared on every state change
    logic [14:0] wd_q;           // watchdog, cleared on every state change
    logic        s1_prev_q, s1_rise_q;
    logic        s2_prev_q, s2_rise_q;
    logic        ld_ready_q, busy_q, wv_q, err_q, infer_done_q;
    logic        stage1_start_q, stage2_start_q;
    logic [15:0] wr_data_q;
    logic        w12_we_q, b12_we_q, w23_we_q, b23_we_q, img_we_q;
    logic [12:0] w12_addr_q;
    logic [4:0]  b12_addr_q;
    logic [7:0]  w23_addr_q;
    logic [3:0]  b23_addr_q;
    logic [8:0]  img_addr_q;
    logic        accept_s;
    logic        cmd_state_s;

    function automatic logic is_load(input state_t s);
        return (s == LD_W12) || (s == LD_B12) || (s == LD_W23) ||
               (s == LD_B23) || (s == LD_IMG);
    endfunction

    // ld_ready_q is high exactly while the state is a load state
    assign accept_s    = ld_valid & ld_ready_q;
    assign cmd_state_s = (state_q == IDLE) || (state_q == READY);

    // Next-state decode: command priority, load progression and stage waits
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: begin
                if (cmd_load_all) begin
                    state_d = LD_W12;
                end else if (cmd_load_img && wv_q) begin
                    state_d = LD_IMG;
                end else if (cmd_run && (state_q == READY)) begin
                    state_d = S1_START;
                end else begin
                    state_d = state_q;
                end
            end
            LD_W12: begin
                if (accept_s && (cnt_q == 13'(W12_LAST))) state_d = LD_B12;
                else                                      state_d = LD_W12;
            end
            LD_B12: begin
                if (accept_s && (cnt_q == 13'(B12_LAST))) state_d = LD_W23;
                else                                      state_d = LD_B12;
            end
            LD_W23: begin
                if (accept_s && (cnt_q == 13'(W23_LAST))) state_d = LD_B23;
                else                                      state_d = LD_W23;
            end
            LD_B23: begin
                if (accept_s && (cnt_q == 13'(B23_LAST))) state_d = LD_IMG;
                else                                      state_d = LD_B23;
            end
            LD_IMG: begin
                if (accept_s && (cnt_q == 13'(IMG_LAST))) state_d = READY;
                else                                      state_d = LD_IMG;
            end
            S1_START: state_d = S1_WAIT;
            S1_WAIT: begin
                if (s1_rise_q)                         state_d = S2_START;
                else if (wd_q == 15'(TIMEOUT - 1))     state_d = ERROR;
                else                                   state_d = S1_WAIT;
            end
            S2_START: state_d = S2_WAIT;
            S2_WAIT: begin
                if (s2_rise_q)                         state_d = DONE;
                else if (wd_q == 15'(TIMEOUT - 1))     state_d = ERROR;
                else                                   state_d = S2_WAIT;
            end
            DONE:    state_d = READY;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // State, counters, edge detectors and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 13'd0;
            wd_q           <= 15'd0;
            s1_prev_q      <= 1'b0;
            s1_rise_q      <= 1'b0;
            s2_prev_q      <= 1'b0;
            s2_rise_q      <= 1'b0;
            ld_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            wv_q           <= 1'b0;
            err_q          <= 1'b0;
            infer_done_q   <= 1'b0;
            stage1_start_q <= 1'b0;
            stage2_start_q <= 1'b0;
            wr_data_q      <= 16'd0;
            w12_we_q       <= 1'b0;
            b12_we_q       <= 1'b0;
            w23_we_q       <= 1'b0;
            b23_we_q       <= 1'b0;
            img_we_q       <= 1'b0;
            w12_addr_q     <= 13'd0;
            b12_addr_q     <= 5'd0;
            w23_addr_q     <= 8'd0;
            b23_addr_q     <= 4'd0;
            img_addr_q     <= 9'd0;
        end else begin
            state_q <= state_d;

            // Counters restart at 0 whenever the state changes
            if (state_d != state_q) begin
                cnt_q <= 13'd0;
            end else if (accept_s) begin
                cnt_q <= cnt_q + 13'd1;
            end else begin
                cnt_q <= cnt_q;
            end

            if (state_d != state_q) begin
                wd_q <= 15'd0;
            end else if ((state_q == S1_WAIT) || (state_q == S2_WAIT)) begin
                wd_q <= wd_q + 15'd1;
            end else begin
                wd_q <= wd_q;
            end

            // Edge detect is free-running; the rise pulse lasts one cycle so a
            // rise seen outside the matching WAIT state is simply dropped.
            s1_prev_q <= stage1_done;
            s1_rise_q <= stage1_done & ~s1_prev_q;
            s2_prev_q <= stage2_done;
            s2_rise_q <= stage2_done & ~s2_prev_q;

            // Status outputs decode the state being entered so they line up with it
            ld_ready_q     <= is_load(state_d);
            busy_q         <= !((state_d == IDLE) || (state_d == READY) || (state_d == ERROR));
            stage1_start_q <= (state_d == S1_START);
            stage2_start_q <= (state_d == S2_START);
            infer_done_q   <= (state_d == DONE);
            err_q          <= (state_d == ERROR);

            if (cmd_state_s && cmd_load_all) begin
                wv_q <= 1'b0;
            end else if ((state_q == LD_B23) && (state_d == LD_IMG)) begin
                wv_q <= 1'b1;
            end else begin
                wv_q <= wv_q;
            end

            // Write bus: one enable per accepted beat, address = beat counter
            w12_we_q <= accept_s && (state_q == LD_W12);
            b12_we_q <= accept_s && (state_q == LD_B12);
            w23_we_q <= accept_s && (state_q == LD_W23);
            b23_we_q <= accept_s && (state_q == LD_B23);
            img_we_q <= accept_s && (state_q == LD_IMG);

            if (accept_s) begin
                wr_data_q <= ld_data;
            end else begin
                wr_data_q <= wr_data_q;
            end

            if (accept_s && (state_q == LD_W12)) w12_addr_q <= cnt_q;
            else                                 w12_addr_q <= w12_addr_q;
            if (accept_s && (state_q == LD_B12)) b12_addr_q <= cnt_q[4:0];
            else                                 b12_addr_q <= b12_addr_q;
            if (accept_s && (state_q == LD_W23)) w23_addr_q <= cnt_q[7:0];
            else                                 w23_addr_q <= w23_addr_q;
            if (accept_s && (state_q == LD_B23)) b23_addr_q <= cnt_q[3:0];
            else                                 b23_addr_q <= b23_addr_q;
            if (accept_s && (state_q == LD_IMG)) img_addr_q <= cnt_q[8:0];
            else                                 img_addr_q <= img_addr_q;
        end
    end

    assign ld_ready      = ld_ready_q;
    assign wr_data       = wr_data_q;
    assign w12_we        = w12_we_q;
    assign w12_addr      = w12_addr_q;
    assign b12_we        = b12_we_q;
    assign b12_addr      = b12_addr_q;
    assign w23_we        = w23_we_q;
    assign w23_addr      = w23_addr_q;
    assign b23_we        = b23_we_q;
    assign b23_addr      = b23_addr_q;
    assign img_we        = img_we_q;
    assign img_addr      = img_addr_q;
    assign stage1_start  = stage1_start_q;
    assign stage2_start  = stage2_start_q;
    assign busy          = busy_q;
    assign weights_valid = wv_q;
    assign infer_done    = infer_done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_inference_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inference_seq_ctrl
//
// Self-checking bench for inference_seq_ctrl. Load beats push their expected
// {memory, address, data} onto a scoreboard queue; a negedge monitor pops and
// compares each memory write. Command acceptance from IDLE is table-driven;
// run, image reload, watchdog and reset behaviour are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_inference_seq_ctrl;

    localparam int TOTAL   = 5606;
    localparam int IMG_IDX = 5350;
    localparam int TMO     = 16384;

    logic        clk, reset;
    logic        cmd_load_all, cmd_load_img, cmd_run;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic [15:0] wr_data;
    logic        w12_we, b12_we, w23_we, b23_we, img_we;
    logic [12:0] w12_addr;
    logic [4:0]  b12_addr;
    logic [7:0]  w23_addr;
    logic [3:0]  b23_addr;
    logic [8:0]  img_addr;
    logic        stage1_start, stage2_start, stage1_done, stage2_done;
    logic        busy, weights_valid, infer_done, err;

    inference_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_load_all(cmd_load_all), .cmd_load_img(cmd_load_img), .cmd_run(cmd_run),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .wr_data(wr_data),
        .w12_we(w12_we), .w12_addr(w12_addr),
        .b12_we(b12_we), .b12_addr(b12_addr),
        .w23_we(w23_we), .w23_addr(w23_addr),
        .b23_we(b23_we), .b23_addr(b23_addr),
        .img_we(img_we), .img_addr(img_addr),
        .stage1_start(stage1_start), .stage2_start(stage2_start),
        .stage1_done(stage1_done), .stage2_done(stage2_done),
        .busy(busy), .weights_valid(weights_valid),
        .infer_done(infer_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  mem;
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic all, img, run;
        logic exp_ready, exp_busy, exp_s1;
    } vec_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  s1_pulses = 0, s2_pulses = 0, inf_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wr_t exp_for(input int k, input logic [15:0] d);
        wr_t w;
        if (k < 5120)      begin w.mem = 3'd0; w.addr = 13'(k); end
        else if (k < 5140) begin w.mem = 3'd1; w.addr = 13'(k - 5120); end
        else if (k < 5340) begin w.mem = 3'd2; w.addr = 13'(k - 5140); end
        else if (k < 5350) begin w.mem = 3'd3; w.addr = 13'(k - 5340); end
        else               begin w.mem = 3'd4; w.addr = 13'(k - 5350); end
        w.data = d;
        return w;
    endfunction

    // Write monitor: at most one enable, each write must match the scoreboard head
    always @(negedge clk) begin
        int  n;
        wr_t act, e;
        n = int'(w12_we) + int'(b12_we) + int'(w23_we) + int'(b23_we) + int'(img_we);
        act = '0;
        if (n > 1) begin
            chk("we_onehot", 32'(n), 32'd1);
        end else if (n == 1) begin
            if (w12_we)      act = {3'd0, w12_addr, wr_data};
            else if (b12_we) act = {3'd1, 8'd0, b12_addr, wr_data};
            else if (w23_we) act = {3'd2, 5'd0, w23_addr, wr_data};
            else if (b23_we) act = {3'd3, 9'd0, b23_addr, wr_data};
            else             act = {3'd4, 4'd0, img_addr, wr_data};
            if (sb.size() == 0) begin
                chk("write_unexpected", act, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("write", act, e);
            end
        end
        if (!reset) begin
            s1_pulses  += int'(stage1_start);
            s2_pulses  += int'(stage2_start);
            inf_pulses += int'(infer_done);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        cmd_load_all = 1'b0; cmd_load_img = 1'b0; cmd_run = 1'b0;
        ld_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Pulse one command set for one cycle; returns #1 after the sampling edge
    task automatic pulse_cmd(input logic a, input logic i, input logic r);
        cmd_load_all = a; cmd_load_img = i; cmd_run = r;
        @(posedge clk); #1;
        cmd_load_all = 1'b0; cmd_load_img = 1'b0; cmd_run = 1'b0;
    endtask

    // Drive beats first..first+count-1, optionally with an idle cycle after each
    task automatic do_load(input int first, input int count, input bit toggle);
        logic [15:0] d;
        for (int k = first; k < first + count; k++) begin
            d = 16'($urandom);
            ld_valid = 1'b1;
            ld_data  = d;
            sb.push_back(exp_for(k, d));
            @(posedge clk); #1;
            if (toggle) begin
                ld_valid = 1'b0;
                ld_data  = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        ld_valid = 1'b0;
    endtask

    task automatic full_load(input bit toggle, input string tag);
        pulse_cmd(1'b1, 1'b0, 1'b0);
        chk({tag, "_ld_ready_on"}, 32'(ld_ready), 32'd1);
        chk({tag, "_wv_cleared"}, 32'(weights_valid), 32'd0);
        do_load(0, TOTAL, toggle);
        @(posedge clk); #1;
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_ready_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready_ld_ready"}, 32'(ld_ready), 32'd0);
        chk({tag, "_weights_valid"}, 32'(weights_valid), 32'd1);
    endtask

    vec_t vecs[5];
    int   s1_base, s2_base, inf_base;

    initial begin
        stage1_done = 1'b0;
        stage2_done = 1'b0;
        ld_data     = 16'd0;
        vecs[0] = '{all:1'b0, img:1'b0, run:1'b1, exp_ready:1'b0, exp_busy:1'b0, exp_s1:1'b0};
        vecs[1] = '{all:1'b0, img:1'b1, run:1'b0, exp_ready:1'b0, exp_busy:1'b0, exp_s1:1'b0};
        vecs[2] = '{all:1'b0, img:1'b1, run:1'b1, exp_ready:1'b0, exp_busy:1'b0, exp_s1:1'b0};
        vecs[3] = '{all:1'b1, img:1'b0, run:1'b1, exp_ready:1'b1, exp_busy:1'b1, exp_s1:1'b0};
        vecs[4] = '{all:1'b1, img:1'b1, run:1'b1, exp_ready:1'b1, exp_busy:1'b1, exp_s1:1'b0};

        do_reset();
        chk("rst_status", 32'({ld_ready, busy, weights_valid, infer_done, err,
                               stage1_start, stage2_start}), 32'd0);
        chk("rst_we", 32'({w12_we, b12_we, w23_we, b23_we, img_we}), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_addr", 32'(w12_addr) | 32'(b12_addr) | 32'(w23_addr) |
                        32'(b23_addr) | 32'(img_addr), 32'd0);

        // Command acceptance from IDLE
        for (int i = 0; i < 5; i++) begin
            do_reset();
            pulse_cmd(vecs[i].all, vecs[i].img, vecs[i].run);
            chk($sformatf("idle_vec%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("idle_vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            chk($sformatf("idle_vec%0d_s1", i), 32'(stage1_start), 32'(vecs[i].exp_s1));
            @(posedge clk); #1;
            chk($sformatf("idle_vec%0d_hold", i), 32'(ld_ready), 32'(vecs[i].exp_ready));
        end
        do_reset();

        // Full back-to-back load
        full_load(1'b0, "load_b2b");

        // One inference
        s1_base = s1_pulses; s2_base = s2_pulses; inf_base = inf_pulses;
        pulse_cmd(1'b0, 1'b0, 1'b1);
        chk("run_s1_start", 32'(stage1_start), 32'd1);
        chk("run_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("run_s1_single", 32'(stage1_start), 32'd0);
        repeat (5138) @(posedge clk);
        #1 stage1_done = 1'b1;
        @(posedge clk); #1;
        chk("run_s2_early", 32'(stage2_start), 32'd0);
        @(posedge clk); #1;
        chk("run_s2_start", 32'(stage2_start), 32'd1);
        @(posedge clk); #1;
        chk("run_s2_single", 32'(stage2_start), 32'd0);
        repeat (298) @(posedge clk);
        #1 stage2_done = 1'b1;
        @(posedge clk); #1;
        chk("run_infer_early", 32'(infer_done), 32'd0);
        @(posedge clk); #1;
        chk("run_infer_done", 32'(infer_done), 32'd1);
        @(posedge clk); #1;
        chk("run_infer_single", 32'(infer_done), 32'd0);
        chk("run_ready_busy", 32'(busy), 32'd0);
        chk("run_err", 32'(err), 32'd0);
        stage1_done = 1'b0; stage2_done = 1'b0;
        @(posedge clk); #1;
        chk("run_s1_count", 32'(s1_pulses - s1_base), 32'd1);
        chk("run_s2_count", 32'(s2_pulses - s2_base), 32'd1);
        chk("run_inf_count", 32'(inf_pulses - inf_base), 32'd1);

        // Coincident load_img and run: image reload wins
        s1_base = s1_pulses;
        pulse_cmd(1'b0, 1'b1, 1'b1);
        chk("img_ld_ready", 32'(ld_ready), 32'd1);
        chk("img_no_s1", 32'(stage1_start), 32'd0);
        chk("img_wv_kept", 32'(weights_valid), 32'd1);
        do_load(IMG_IDX, 256, 1'b0);
        @(posedge clk); #1;
        chk("img_sb_empty", 32'(sb.size()), 32'd0);
        chk("img_ready_busy", 32'(busy), 32'd0);
        chk("img_ld_ready_off", 32'(ld_ready), 32'd0);
        chk("img_s1_count", 32'(s1_pulses - s1_base), 32'd0);

        // Full load with ld_valid toggling every other cycle
        full_load(1'b1, "load_tog");

        // Watchdog: stage1_done never rises
        pulse_cmd(1'b0, 1'b0, 1'b1);
        chk("wd_s1_start", 32'(stage1_start), 32'd1);
        repeat (TMO) @(posedge clk);
        #1 chk("wd_err_not_yet", 32'(err), 32'd0);
        @(posedge clk); #1;
        chk("wd_err_set", 32'(err), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        pulse_cmd(1'b1, 1'b1, 1'b1);
        chk("wd_cmd_ignored", 32'(ld_ready), 32'd0);
        chk("wd_wv_kept", 32'(weights_valid), 32'd1);
        stage1_done = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("wd_err_sticky", 32'(err), 32'd1);
        chk("wd_no_s2", 32'(stage2_start), 32'd0);
        stage1_done = 1'b0;
        do_reset();
        chk("wd_reset_err", 32'(err), 32'd0);
        chk("wd_reset_wv", 32'(weights_valid), 32'd0);

        // Reset in the middle of a load
        pulse_cmd(1'b1, 1'b0, 1'b0);
        do_load(0, 10, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wv", 32'(weights_valid), 32'd0);
        @(posedge clk); #1;
        chk("midrst_idle", 32'(ld_ready), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
